// File: rtl/sfu_fifo_pkg.sv
// Shared definitions for the SFU stream FIFO: default geometry, threshold
// defaults, pointer-width helper and the registered status bundle.
package sfu_fifo_pkg;

    localparam int SFU_FIFO_DEFAULT_WIDTH     = 32;
    localparam int SFU_FIFO_DEFAULT_DEPTH     = 16;
    // almost_full default sits this many entries below full
    localparam int SFU_FIFO_DEFAULT_AF_MARGIN = 2;
    localparam int SFU_FIFO_DEFAULT_AE_THRESH = 2;

    // Level field is sized for the largest supported depth (2^15 entries);
    // the top level narrows it to its own pointer width.
    localparam int SFU_FIFO_LEVEL_MAX_W = 16;

    typedef struct packed {
        logic                            full;
        logic                            empty;
        logic                            almost_full;
        logic                            almost_empty;
        logic [SFU_FIFO_LEVEL_MAX_W-1:0] level;
    } sfu_fifo_status_t;

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int sfu_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sfu_fifo_mem.sv
// Storage array for the SFU stream FIFO: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module sfu_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] entry_q [FIFO_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;

            // Capture write data into this slot when it is the write target
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Head entry is visible in the same cycle its address is presented
    assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/sfu_stream_fifo.sv
// Valid/ready first-word-fall-through FIFO between SFU operand fetch and one
// FPU lane. Wrap-bit pointers, registered level and status flags, synchronous
// flush. Optional macro SFU_FIFO_BYPASS_EN adds a zero-latency path from
// in_data to out_data when the FIFO is empty and the consumer is ready.
module sfu_stream_fifo
    import sfu_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SFU_FIFO_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = SFU_FIFO_DEFAULT_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - SFU_FIFO_DEFAULT_AF_MARGIN,
    parameter int AE_THRESH  = SFU_FIFO_DEFAULT_AE_THRESH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int PTR_W  = sfu_ptr_width(FIFO_DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

    // Status seen in the cycle after reset: nothing stored
    localparam sfu_fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  (AF_THRESH <= 0),
        almost_empty: (AE_THRESH >= 0),
        level:        '0
    };

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_next;
    logic [PTR_W-1:0]      level_next;
    sfu_fifo_status_t      status_reg;
    sfu_fifo_status_t      status_next;

    logic                  head_valid;
    logic                  bypass_fire;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_level_hi;

    sfu_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // No pass-through when full, and nothing is accepted during flush/reset
    assign in_ready   = !status_reg.full && !flush && !rst;
    assign head_valid = !status_reg.empty;
    assign push       = in_valid && in_ready;

`ifdef SFU_FIFO_BYPASS_EN
    // Empty FIFO with a ready consumer: hand the producer's word straight over
    assign bypass_fire = status_reg.empty && in_valid && in_ready && out_ready;
`else
    assign bypass_fire = 1'b0;
`endif

    assign out_valid = head_valid || bypass_fire;
    assign pop       = out_valid && out_ready;

    // A bypassed word is consumed without touching storage or pointers
    assign wr_en = push && !bypass_fire;
    assign rd_en = pop && !bypass_fire;

    assign out_data = bypass_fire ? in_data :
                      (head_valid ? rd_data : '0);

    assign level           = status_reg.level[PTR_W-1:0];
    assign full            = status_reg.full;
    assign empty           = status_reg.empty;
    assign almost_full     = status_reg.almost_full;
    assign almost_empty    = status_reg.almost_empty;
    assign unused_level_hi = |status_reg.level[SFU_FIFO_LEVEL_MAX_W-1:PTR_W];

    // Next pointers and the status they imply; flush wins over any transfer
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
        end

        level_next = wr_ptr_next - rd_ptr_next;

        status_next              = '0;
        status_next.full         = (wr_ptr_next[PTR_W-1] != rd_ptr_next[PTR_W-1]) &&
                                   (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
        status_next.empty        = (wr_ptr_next == rd_ptr_next);
        status_next.almost_full  = (level_next >= AF_LVL);
        status_next.almost_empty = (level_next <= AE_LVL);
        status_next.level        = SFU_FIFO_LEVEL_MAX_W'(level_next);
    end

    // Pointers and status registers move together so flags always match level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            status_reg <= STATUS_RST;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            status_reg <= status_next;
        end
    end

endmodule

// File: doc/sfu_stream_fifo.md
# sfu_stream_fifo

Parametrised valid/ready stream FIFO for the SFU datapath, the successor to the SFU's plain read/write-enable operand buffer. It adds backpressure handshakes, first-word-fall-through output, an occupancy count, programmable almost-full/almost-empty flags and a synchronous flush. It sits between the SFU operand fetch and the FPU lanes, one instance per lane.

## Interface
- `DATA_WIDTH`, 32: payload width in bits, ≥1.
- `FIFO_DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_THRESH`, FIFO_DEPTH-2: `almost_full` asserts when level ≥ AF_THRESH.
- `AE_THRESH`, 2: `almost_empty` asserts when level ≤ AE_THRESH.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous clear of contents.
- `in_valid` in 1: producer has data.
- `in_ready` out 1: FIFO accepts data.
- `in_data` in DATA_WIDTH: write payload.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer takes head.
- `out_data` out DATA_WIDTH: head payload.
- `level` out $clog2(FIFO_DEPTH)+1: current occupancy, 0..FIFO_DEPTH.
- `full` out 1: level == FIFO_DEPTH.
- `empty` out 1: level == 0.
- `almost_full` out 1: per AF_THRESH.
- `almost_empty` out 1: per AE_THRESH.

## Operation
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`. Only handshaked transfers move data.
- `in_ready` = !full & !flush & !rst. There is no pass-through when full: a simultaneous pop does not free space in the same cycle.
- `out_valid` = !empty. `out_data` is the head entry read combinationally from registered storage (FWFT). When `out_valid`=0, `out_data` is forced to 0.
- Read and write pointers are $clog2(FIFO_DEPTH)+1 bits wide, and the extra MSB is the wrap bit.
  - full: MSBs differ and the low bits are equal.
  - empty: the pointers are equal.
- `level` = wr_ptr − rd_ptr, taken modulo 2^($clog2(FIFO_DEPTH)+1). It is a registered value and is updated together with the pointers.
- Simultaneous push and pop (non-full, non-empty) leaves `level` unchanged. Both pointers advance.
- Pointer wrap: after FIFO_DEPTH pushes, the low bits return to 0 and the MSB toggles. No entry is lost.
- Push while empty: the entry is written and `out_valid` rises next cycle. `out_ready` in the push cycle has no effect (base build).
- `flush`: on the next edge both pointers are zeroed and `level` becomes 0. Flush overrides any push or pop in the same cycle, and that push is not accepted because `in_ready`=0.
- `rst`: identical to flush, and also clears any internal registers. Storage contents are not reset.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `level`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0.
  - `out_valid`=0, `out_data`=0.
  - `in_ready`=0 while `rst` is high and 1 the first cycle after release.
- Push-to-out_valid latency: 1 cycle (base build).
- Throughput: 1 push and 1 pop per cycle, sustained.
- All status flags derive from the registered pointers and are valid in the same cycle as `level`.
- Reset or flush asserted mid-stream discards all queued data. Any handshake in that cycle is void.

## Configuration
- `SFU_FIFO_BYPASS_EN` defined: when empty and `in_valid & out_ready` are both high, `in_data` is presented on `out_data` with `out_valid`=1 in the same cycle. The transfer completes with 0 latency, the data is not stored, and `level` stays 0.
- `SFU_FIFO_BYPASS_EN` not defined: no combinational in-to-out path. The empty-cycle push is stored and appears after 1 cycle.

## Structure
- `sfu_fifo_pkg` holds the pointer-width function (clog2+1), the default depth and threshold constants, and a status struct {full, empty, almost_full, almost_empty, level}.
- Sub-module `sfu_fifo_mem`: a FIFO_DEPTH×DATA_WIDTH register array with one synchronous write port and one combinational read port. It has no reset.
- The top level holds the pointers, flags, handshake logic and bypass mux.

## Test plan
- Reset, then push 0xA0..0xAF back-to-back with out_ready=0 -> `level` reaches 16, `full`=1, `in_ready`=0, and a 17th push is not accepted. Then drain -> data 0xA0..0xAF in order, then `empty`=1 and `out_data`=0.
- Steady streaming for 40 cycles with in_valid=out_ready=1 after one primed entry -> `level` stays 1, data emerges in order, and the pointers wrap twice with no loss.
- Fill to 14 with defaults -> `almost_full` rises on the 14th push. Pop to 2 -> `almost_empty` rises on reaching 2.
- Full FIFO with a simultaneous push attempt and pop -> pop accepted, push rejected, `level`=15 next cycle.
- Push 5 entries, then assert `flush` together with a push of 0x55 -> next cycle `level`=0 and `empty`=1, and 0x55 is never output.
- Empty FIFO, push 0x77 with out_ready=1:
  - with `SFU_FIFO_BYPASS_EN`: 0x77 is output the same cycle and `level` stays 0.
  - without it: 0x77 is output the next cycle.
